// File: rtl/freq_cache_bank_if.sv
// Drain-side ready/valid bus of freq_cache_bank.
// One beat carries either a zero-extended stream word or a {hash,occ} table entry.
interface freq_cache_bank_if #(
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 7
);
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_sel;
    logic [AW-1:0]           out_addr;
    logic [2*DATA_WIDTH-1:0] out_data;

    modport master (output out_valid, out_sel, out_addr, out_data, input out_ready);
    modport slave  (input out_valid, out_sel, out_addr, out_data, output out_ready);
endinterface

// File: rtl/freq_cache_bank.sv
// freq_cache_bank: one processor's stream slice and hash/occurrence table, with table clear and ready/valid drain.
// Build option FCB_ZERO_SKIP_EN: the table phase of a drain skips entries whose occurrence count is zero.
module freq_cache_bank #(
    parameter  int DATA_WIDTH   = 32,
    parameter  int STREAM_DEPTH = 100,
    parameter  int HASH_BITS    = 7,
    localparam int SA           = ($clog2(STREAM_DEPTH) > 1) ? $clog2(STREAM_DEPTH) : 1,
    localparam int HA           = HASH_BITS,
    localparam int HD           = 2 ** HASH_BITS,
    localparam int AW           = (SA > HA) ? SA : HA
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SA-1:0]           rd_idx,
    output logic [DATA_WIDTH-1:0]   rd_data,
    input  logic [HA-1:0]           ht_rd_addr,
    output logic [DATA_WIDTH-1:0]   ht_rd_hash,
    output logic [DATA_WIDTH-1:0]   ht_rd_occ,
    input  logic                    ht_wr_en,
    input  logic [HA-1:0]           ht_wr_addr,
    input  logic [DATA_WIDTH-1:0]   ht_wr_hash,
    input  logic [DATA_WIDTH-1:0]   ht_wr_occ,
    output logic                    busy,
    input  logic                    ld_en,
    input  logic [SA-1:0]           ld_addr,
    input  logic [DATA_WIDTH-1:0]   ld_data,
    input  logic                    ht_ld_en,
    input  logic [HA-1:0]           ht_ld_addr,
    input  logic [2*DATA_WIDTH-1:0] ht_ld_data,
    input  logic                    clr_start,
    input  logic                    drain_start,
    output logic                    drain_done,
    freq_cache_bank_if.master       drain
);

    // state   | meaning
    // IDLE    | waiting for clr_start / drain_start; core table writes honoured
    // CLEAR   | zeroing table entry clr_cnt, one per cycle
    // DRAIN_S | issuing stream reads 0..STREAM_DEPTH-1
    // DRAIN_H | issuing table reads 0..HD-1, then waiting for the skid to empty
    // DONE    | one-cycle drain_done pulse
    typedef enum logic [2:0] {IDLE, CLEAR, DRAIN_S, DRAIN_H, DONE} state_t;

    localparam logic [SA:0]   SD_LIM = (SA + 1)'(STREAM_DEPTH);
    localparam logic [AW-1:0] S_LAST = AW'(STREAM_DEPTH - 1);
    localparam logic [AW-1:0] H_LAST = AW'(HD - 1);
    localparam logic [HA-1:0] C_LAST = HA'(HD - 1);

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] s_mem [STREAM_DEPTH];
    logic [DATA_WIDTH-1:0] h_mem [HD];
    logic [DATA_WIDTH-1:0] o_mem [HD];

    logic                    s_we;
    logic                    t_we;
    logic [HA-1:0]           t_wa;
    logic [DATA_WIDTH-1:0]   t_wh;
    logic [DATA_WIDTH-1:0]   t_wo;

    logic [HA-1:0]           clr_cnt;
    logic [AW-1:0]           iss_addr;
    logic                    iss_end;
    logic                    issue;

    logic                    p_valid;
    logic                    p_sel;
    logic [AW-1:0]           p_addr;
    logic [2*DATA_WIDTH-1:0] p_data;

    logic                    f_sel  [2];
    logic [AW-1:0]           f_addr [2];
    logic [2*DATA_WIDTH-1:0] f_data [2];
    logic                    f_rd;
    logic                    f_wr;
    logic [1:0]              f_cnt;
    logic [1:0]              f_occ;
    logic                    room;
    logic                    push;
    logic                    pop;
    logic                    skip;

    assign drain.out_valid = (f_cnt != 2'd0);
    assign drain.out_sel   = f_sel[f_rd];
    assign drain.out_addr  = f_addr[f_rd];
    assign drain.out_data  = f_data[f_rd];

    assign pop   = drain.out_valid && drain.out_ready;
    assign f_occ = f_cnt + {1'b0, p_valid};
    // The skid holds two beats; a read may issue whenever the beat it returns is guaranteed a slot.
    assign room  = (f_occ < 2'd2) || pop;

`ifdef FCB_ZERO_SKIP_EN
    assign skip = p_sel && (p_data[DATA_WIDTH-1:0] == '0);
`else
    assign skip = 1'b0;
`endif
    assign push = p_valid && !skip;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        drain_done = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_nxt = CLEAR;
                end else if (drain_start) begin
                    state_nxt = DRAIN_S;
                end
            end
            CLEAR: begin
                if (clr_cnt == C_LAST) begin
                    state_nxt = IDLE;
                end
            end
            DRAIN_S: begin
                if (room) begin
                    issue = 1'b1;
                    if (iss_addr == S_LAST) begin
                        state_nxt = DRAIN_H;
                    end
                end
            end
            DRAIN_H: begin
                if (!iss_end && room) begin
                    issue = 1'b1;
                end
                if (iss_end && !p_valid && ((f_cnt == 2'd0) || ((f_cnt == 2'd1) && pop))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                drain_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Single table write port: clear, then loader, then core (core only while idle).
    always_comb begin
        t_we = 1'b0;
        t_wa = ht_wr_addr;
        t_wh = ht_wr_hash;
        t_wo = ht_wr_occ;
        if (state == CLEAR) begin
            t_we = rst_n;
            t_wa = clr_cnt;
            t_wh = '0;
            t_wo = '0;
        end else if (ht_ld_en) begin
            t_we = 1'b1;
            t_wa = ht_ld_addr;
            t_wh = ht_ld_data[2*DATA_WIDTH-1:DATA_WIDTH];
            t_wo = ht_ld_data[DATA_WIDTH-1:0];
        end else if (ht_wr_en && (state == IDLE)) begin
            t_we = 1'b1;
        end
    end

    assign s_we = ld_en && ({1'b0, ld_addr} < SD_LIM);

    always_ff @(posedge clk) begin
        if (s_we) begin
            s_mem[ld_addr] <= ld_data;
        end
        if (t_we) begin
            h_mem[t_wa] <= t_wh;
            o_mem[t_wa] <= t_wo;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data    <= '0;
            ht_rd_hash <= '0;
            ht_rd_occ  <= '0;
        end else begin
            rd_data    <= ({1'b0, rd_idx} < SD_LIM) ? s_mem[rd_idx] : '0;
            ht_rd_hash <= h_mem[ht_rd_addr];
            ht_rd_occ  <= o_mem[ht_rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_cnt  <= '0;
            iss_addr <= '0;
            iss_end  <= 1'b0;
            p_valid  <= 1'b0;
            p_sel    <= 1'b0;
            p_addr   <= '0;
            p_data   <= '0;
        end else begin
            p_valid <= issue;
            if (state == IDLE) begin
                clr_cnt  <= '0;
                iss_addr <= '0;
                iss_end  <= 1'b0;
            end
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + HA'(1);
            end
            if (issue) begin
                p_addr <= iss_addr;
                if (state == DRAIN_H) begin
                    p_sel  <= 1'b1;
                    p_data <= {h_mem[iss_addr[HA-1:0]], o_mem[iss_addr[HA-1:0]]};
                end else begin
                    p_sel  <= 1'b0;
                    p_data <= {{DATA_WIDTH{1'b0}}, s_mem[iss_addr[SA-1:0]]};
                end
                if ((state == DRAIN_S) && (iss_addr == S_LAST)) begin
                    iss_addr <= '0;
                end else if ((state == DRAIN_H) && (iss_addr == H_LAST)) begin
                    iss_end <= 1'b1;
                end else begin
                    iss_addr <= iss_addr + AW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_rd  <= 1'b0;
            f_wr  <= 1'b0;
            f_cnt <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                f_sel[i]  <= 1'b0;
                f_addr[i] <= '0;
                f_data[i] <= '0;
            end
        end else begin
            if (push) begin
                f_sel[f_wr]  <= p_sel;
                f_addr[f_wr] <= p_addr;
                f_data[f_wr] <= p_data;
                f_wr         <= ~f_wr;
            end
            if (pop) begin
                f_rd <= ~f_rd;
            end
            f_cnt <= f_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_freq_cache_bank.sv
// Directed + randomized bench for freq_cache_bank against a table/queue reference model.
// Also handles builds with FCB_ZERO_SKIP_EN defined.
module tb_freq_cache_bank;
    localparam int DW = 32;
    localparam int SD = 100;
    localparam int HB = 7;
    localparam int HD = 128;
    localparam int SA = 7;
    localparam int HA = 7;
    localparam int AW = 7;
    localparam int BW = 1 + AW + 2 * DW;
    typedef logic [BW-1:0] beat_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [SA-1:0]   rd_idx;
    logic [DW-1:0]   rd_data;
    logic [HA-1:0]   ht_rd_addr;
    logic [DW-1:0]   ht_rd_hash;
    logic [DW-1:0]   ht_rd_occ;
    logic            ht_wr_en;
    logic [HA-1:0]   ht_wr_addr;
    logic [DW-1:0]   ht_wr_hash;
    logic [DW-1:0]   ht_wr_occ;
    logic            busy;
    logic            ld_en;
    logic [SA-1:0]   ld_addr;
    logic [DW-1:0]   ld_data;
    logic            ht_ld_en;
    logic [HA-1:0]   ht_ld_addr;
    logic [2*DW-1:0] ht_ld_data;
    logic            clr_start;
    logic            drain_start;
    logic            drain_done;

    freq_cache_bank_if #(.DATA_WIDTH(DW), .AW(AW)) drain_bus ();

    freq_cache_bank #(.DATA_WIDTH(DW), .STREAM_DEPTH(SD), .HASH_BITS(HB)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_idx(rd_idx), .rd_data(rd_data),
        .ht_rd_addr(ht_rd_addr), .ht_rd_hash(ht_rd_hash), .ht_rd_occ(ht_rd_occ),
        .ht_wr_en(ht_wr_en), .ht_wr_addr(ht_wr_addr), .ht_wr_hash(ht_wr_hash), .ht_wr_occ(ht_wr_occ),
        .busy(busy),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ht_ld_en(ht_ld_en), .ht_ld_addr(ht_ld_addr), .ht_ld_data(ht_ld_data),
        .clr_start(clr_start), .drain_start(drain_start), .drain_done(drain_done),
        .drain(drain_bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] s_ref [SD];
    logic [DW-1:0] h_ref [HD];
    logic [DW-1:0] o_ref [HD];
    beat_t         exp_q [$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic build_exp();
        exp_q.delete();
        for (int i = 0; i < SD; i++) begin
            exp_q.push_back({1'b0, AW'(i), DW'(0), s_ref[i]});
        end
        for (int j = 0; j < HD; j++) begin
`ifdef FCB_ZERO_SKIP_EN
            if (o_ref[j] == '0) continue;
`endif
            exp_q.push_back({1'b1, AW'(j), h_ref[j], o_ref[j]});
        end
    endtask

    task automatic tbl_load(input int a, input logic [DW-1:0] hv, input logic [DW-1:0] ov);
        ht_ld_en   = 1'b1;
        ht_ld_addr = HA'(a);
        ht_ld_data = {hv, ov};
        h_ref[a]   = hv;
        o_ref[a]   = ov;
        step();
        ht_ld_en   = 1'b0;
    endtask

    task automatic tbl_read_check(input string tag, input int a);
        ht_rd_addr = HA'(a);
        step();
        check({tag, "_hash"}, ht_rd_hash, h_ref[a]);
        check({tag, "_occ"}, ht_rd_occ, o_ref[a]);
    endtask

    task automatic clear_run(input string tag, input bit with_drain);
        int n = 0;
        int seen_valid = 0;
        clr_start   = 1'b1;
        drain_start = with_drain;
        step();
        clr_start   = 1'b0;
        drain_start = 1'b0;
        while (busy && n < 1000) begin
            if (drain_bus.out_valid || drain_done) seen_valid++;
            n++;
            step();
        end
        check({tag, "_busy_cycles"}, n, 128);
        check({tag, "_no_drain"}, seen_valid, 0);
        for (int j = 0; j < HD; j++) begin
            h_ref[j] = '0;
            o_ref[j] = '0;
        end
    endtask

    task automatic run_drain(input bit bp, input string tag);
        beat_t cur;
        beat_t prev = '0;
        bit    prev_stall = 1'b0;
        int    n_acc = 0;
        int    n_exp;
        int    cyc = 0;
        int    done_early = 0;
        int    wt = 0;
        build_exp();
        n_exp = exp_q.size();
        drain_bus.out_ready = 1'b1;
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
        check({tag, "_busy_rise"}, busy, 1);
        check({tag, "_valid_e0"}, drain_bus.out_valid, 0);
        ht_wr_en   = 1'b1;
        ht_wr_addr = HA'(20);
        ht_wr_hash = 32'hDEAD;
        ht_wr_occ  = 32'd77;
        step();
        ht_wr_en = 1'b0;
        check({tag, "_valid_e1"}, drain_bus.out_valid, 0);
        step();
        check({tag, "_first_valid"}, drain_bus.out_valid, 1);
        while (exp_q.size() != 0 && cyc < 5000) begin
            ld_en     = 1'b0;
            clr_start = 1'b0;
            if (bp) drain_bus.out_ready = 1'($urandom_range(0, 1));
            cur = {drain_bus.out_sel, drain_bus.out_addr, drain_bus.out_data};
            if (prev_stall) begin
                check({tag, "_stall_valid"}, drain_bus.out_valid, 1);
                check({tag, "_stall_beat"}, cur, prev);
            end
`ifndef FCB_ZERO_SKIP_EN
            if (!bp) check({tag, "_no_gap"}, drain_bus.out_valid, 1);
`endif
            if (drain_done) done_early++;
            if (drain_bus.out_valid && drain_bus.out_ready) begin
                check({tag, "_beat"}, cur, exp_q.pop_front());
                n_acc++;
                if (n_acc == 10) begin
                    ld_en     = 1'b1;
                    ld_addr   = '0;
                    ld_data   = 32'h1234_5678;
                    s_ref[0]  = 32'h1234_5678;
                    clr_start = 1'b1;
                end
            end
            prev_stall = drain_bus.out_valid && !drain_bus.out_ready;
            prev = cur;
            step();
            cyc++;
        end
        ld_en     = 1'b0;
        clr_start = 1'b0;
        check({tag, "_timeout"}, cyc < 5000, 1);
        check({tag, "_beat_count"}, n_acc, n_exp);
        check({tag, "_done_early"}, done_early, 0);
        check({tag, "_valid_after"}, drain_bus.out_valid, 0);
        while (!drain_done && wt < 300) begin
            step();
            wt++;
        end
        check({tag, "_done_pulse"}, drain_done, 1);
`ifndef FCB_ZERO_SKIP_EN
        check({tag, "_done_latency"}, wt, 0);
`endif
        step();
        check({tag, "_done_clear"}, drain_done, 0);
        check({tag, "_busy_fall"}, busy, 0);
        drain_bus.out_ready = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int idx;
        rst_n = 1'b0;
        rd_idx = '0; ht_rd_addr = '0;
        ht_wr_en = 1'b0; ht_wr_addr = '0; ht_wr_hash = '0; ht_wr_occ = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        ht_ld_en = 1'b0; ht_ld_addr = '0; ht_ld_data = '0;
        clr_start = 1'b0; drain_start = 1'b0;
        drain_bus.out_ready = 1'b1;

        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_valid", drain_bus.out_valid, 0);
        check("rst_done", drain_done, 0);
        check("rst_sel", drain_bus.out_sel, 0);
        check("rst_addr", drain_bus.out_addr, 0);
        check("rst_data", drain_bus.out_data, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_ht_hash", ht_rd_hash, 0);
        check("rst_ht_occ", ht_rd_occ, 0);
        rst_n = 1'b1;
        step();

        clear_run("clear", 1'b0);
        tbl_read_check("clear_rd5", 5);
        for (int k = 0; k < 6; k++) tbl_read_check("clear_rd", $urandom_range(0, HD - 1));

        ht_wr_en = 1'b1; ht_wr_addr = HA'(3); ht_wr_hash = 32'hA5; ht_wr_occ = 32'd1;
        h_ref[3] = 32'hA5; o_ref[3] = 32'd1;
        step();
        ht_wr_en = 1'b0;
        tbl_read_check("rmw_rd", 3);
        ht_wr_en = 1'b1; ht_wr_occ = 32'd2; ht_rd_addr = HA'(3);
        step();
        ht_wr_en = 1'b0;
        check("rmw_rdw_old", ht_rd_occ, 32'd1);
        o_ref[3] = 32'd2;
        tbl_read_check("rmw_new", 3);

        for (int i = 0; i < 128; i++) begin
            ld_en = 1'b1;
            ld_addr = SA'(i);
            ld_data = (i < SD) ? DW'(i + 1) : (32'hBAD0_0000 | DW'(i));
            if (i < SD) s_ref[i] = DW'(i + 1);
            step();
        end
        ld_en = 1'b0;
        rd_idx = SA'(110);
        step();
        check("stream_oob_rd", rd_data, 0);
        for (int k = 0; k < 8; k++) begin
            idx = $urandom_range(0, SD - 1);
            rd_idx = SA'(idx);
            step();
            check("stream_rd", rd_data, s_ref[idx]);
        end
        rd_idx = SA'(10); ld_en = 1'b1; ld_addr = SA'(10); ld_data = 32'hCAFE;
        step();
        ld_en = 1'b0;
        check("stream_rdw_old", rd_data, s_ref[10]);
        s_ref[10] = 32'hCAFE;
        step();
        check("stream_rdw_new", rd_data, 32'hCAFE);
        s_ref[10] = 32'd11;
        ld_en = 1'b1; ld_data = 32'd11;
        step();
        ld_en = 1'b0;

        for (int j = 0; j < HD; j++) begin
            tbl_load(j, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom));
        end
        for (int k = 0; k < 6; k++) tbl_read_check("tbl_rd", $urandom_range(0, HD - 1));

        ht_ld_en = 1'b1; ht_ld_addr = HA'(40); ht_ld_data = {32'h111, 32'h222};
        ht_wr_en = 1'b1; ht_wr_addr = HA'(40); ht_wr_hash = 32'h333; ht_wr_occ = 32'h444;
        h_ref[40] = 32'h111; o_ref[40] = 32'h222;
        step();
        ht_ld_en = 1'b0; ht_wr_en = 1'b0;
        tbl_read_check("prio_ld_wr", 40);

        run_drain(1'b0, "drain");
        tbl_read_check("wr_dropped", 20);
        rd_idx = '0;
        step();
        check("late_ld", rd_data, 32'h1234_5678);

        run_drain(1'b1, "bp");

        clear_run("clr_drain", 1'b1);
        tbl_read_check("clr_drain_rd", 90);
        tbl_load(7, 32'h77, 32'd3);
        tbl_load(90, 32'h90, 32'd5);
        run_drain(1'b0, "sparse");

        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
        repeat (30) step();
        rst_n = 1'b0;
        step();
        check("midrst_valid", drain_bus.out_valid, 0);
        check("midrst_busy", busy, 0);
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (drain_done || drain_bus.out_valid) n++;
            step();
        end
        check("midrst_no_done", n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/freq_cache_bank.md
# freq_cache_bank

Parametrised successor to the per-processor cache in the data-frequency-extraction pipeline. It holds one processor's input stream slice and its hash/occurrence table. It serves single-cycle-latency reads and writes to the hash core, and performs an internal table clear. A ready/valid drain FSM forwards the stream slice and then the table to the next processor with backpressure, replacing the free-running request/copy scheme.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of stream words, hash values and occurrence counts.
- `STREAM_DEPTH`, 100: stream words held; `SA = max(1, clog2(STREAM_DEPTH))`.
- `HASH_BITS`, 7: table depth `HD = 2**HASH_BITS`; `HA = HASH_BITS`.
- `AW`: `max(SA, HA)`, drain address width (derived).

Ports:
- Clock and reset (one clock; reset is synchronous and active-low):
  - `clk` in 1: clock.
  - `rst_n` in 1: synchronous active-low reset.
- Hash-core side:
  - `rd_idx` in SA: stream read index.
  - `rd_data` out DATA_WIDTH: stream word.
  - `ht_rd_addr` in HA: table read address.
  - `ht_rd_hash`, `ht_rd_occ` out DATA_WIDTH each: table entry.
  - `ht_wr_en`, `ht_wr_addr` (HA), `ht_wr_hash`, `ht_wr_occ` in: table write.
  - `busy` out 1: high in any state other than IDLE.
- Load side (memory controller or previous processor):
  - `ld_en`, `ld_addr` (SA), `ld_data` (DATA_WIDTH) in: stream write.
  - `ht_ld_en`, `ht_ld_addr` (HA), `ht_ld_data` (2·DATA_WIDTH, `{hash,occ}`) in: table write.
- Control:
  - `clr_start` in 1: zero the whole table.
  - `drain_start` in 1: begin drain.
  - `drain_done` out 1: one-cycle pulse.
- Drain output:
  - `out_valid` out 1, `out_ready` in 1: handshake.
  - `out_sel` out 1: 0 = stream word, 1 = table entry.
  - `out_addr` out AW: source address.
  - `out_data` out 2·DATA_WIDTH: stream word zero-extended, or `{hash,occ}`.

## Operation
- All addresses are zero-based. Out-of-range stream addresses (≥ STREAM_DEPTH) are ignored on write and return 0 on read.
- States:
  - IDLE
  - CLEAR
  - DRAIN_S
  - DRAIN_H
  - DONE
- IDLE:
  - `clr_start` → CLEAR. If `clr_start` and `drain_start` are both high, clear wins and drain is dropped.
  - `drain_start` → DRAIN_S.
  - Starts are ignored in all other states.
- CLEAR:
  - Writes entry k = 0..HD-1 to zero, one per cycle. Returns to IDLE after entry HD-1 (HD cycles total).
  - `ht_ld_en` and `ht_wr_en` are ignored.
- DRAIN_S:
  - Emits stream addresses 0..STREAM_DEPTH-1 in order, one per accepted beat, then moves to DRAIN_H.
- DRAIN_H:
  - Emits table entries 0..HD-1, then moves to DONE.
- DONE:
  - Pulses `drain_done` for one cycle, then → IDLE.
- Table write priority: clear > `ht_ld_en` > `ht_wr_en`. `ht_wr_en` is honoured only in IDLE; it is dropped otherwise, and the core must watch `busy`.
- `ld_en` is honoured in every state. A load to an address already emitted is not re-sent.
- Reads on `rd_*` and `ht_rd_*` are serviced in every state.
- Read-during-write to the same address returns the old data.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `out_valid`, `drain_done`, `out_sel`, `out_addr` = 0.
  - `out_data`, `rd_data`, `ht_rd_hash`, `ht_rd_occ` = 0.
  - Memory contents are not reset.
- Reset asserted mid-drain or mid-clear aborts immediately. The next cycle is IDLE with `out_valid`=0.
- Core reads have 1-cycle latency: address at edge n, data valid after edge n+1.
- First `out_valid` occurs 2 cycles after the `drain_start` edge.
- With `out_ready` held high, the drain sustains 1 beat/cycle, including across the S→H boundary.
- `out_valid`, `out_sel`, `out_addr` and `out_data` are held stable while `out_valid && !out_ready`. An internal 2-entry skid absorbs the read latency.
- `out_valid` never drops without a handshake.
- `drain_done` is asserted on the cycle after the final accepted beat.
- `busy` rises on the cycle after the accepted start.

## Configuration
- `FCB_ZERO_SKIP_EN` defined:
  - In DRAIN_H, entries with `occ == 0` are not emitted; each skipped entry costs one cycle.
  - If all entries are zero, DRAIN_H emits nothing and `drain_done` still pulses.
- Undefined: all HD entries are emitted unconditionally.

## Test plan
- Reset then CLEAR:
  - `rst_n`=0 for 2 cycles, then `clr_start`. `busy`=1 for exactly 128 cycles (HASH_BITS=7).
  - Afterwards `ht_rd_addr`=5 → `ht_rd_hash`=0, `ht_rd_occ`=0.
- Core RMW:
  - In IDLE, write addr 3 = {0xA5,1}; read addr 3 the next cycle → {0xA5,1}.
  - Same-cycle read and write to addr 3 with {0xA5,2} → read returns old value 1.
- Full drain, `out_ready`=1, STREAM_DEPTH=100:
  - Stream loaded with data = addr+1.
  - 100 beats with `out_sel`=0 and data 1..100, then 128 table beats.
  - `drain_done` 1 cycle after the last beat; no gap cycles after the first beat.
- Backpressure:
  - Toggle `out_ready` pseudo-randomly. Every beat is stable while stalled.
  - Addresses are gap-free and non-duplicated; 228 beats total.
- Priority:
  - `clr_start`+`drain_start` same cycle → CLEAR only.
  - `ht_wr_en` during DRAIN dropped (entry unchanged).
  - `ht_ld_en`+`ht_wr_en` same address in IDLE → ld value stored.
- `FCB_ZERO_SKIP_EN`:
  - Only entries 7 and 90 nonzero → exactly 2 `out_sel`=1 beats at addresses 7 and 90.
  - Mid-drain reset → `out_valid`=0 the next cycle and no `drain_done`.
